// File: rtl/host_bus_write_queue.sv
// host_bus_write_queue
//
// Host-side front end of the graphics adapter. The asynchronous 8-bit host
// bus is synchronised into the clk domain. A bus transaction commits on the
// synchronised rising edge of cs, using the rs/wren/data values that were
// shadowed while cs was low. The block holds the MODE, ADDR and CTRL
// registers. Screen-RAM writes are queued in a FIFO and drained into the
// screen RAM write port, one entry per cycle while the RAM accepts.
//
// Optional feature macro: FGA_AUTOINC_EN
//   defined   - ADDR auto-increment after each accepted DATA push.
//               CTRL bit0 is R/W and resets to 1.
//   undefined - no incrementer. CTRL bit0 reads 0 and ignores writes.
//
// Ports
//   clk            in   clock, all flops on the rising edge
//   rst_n          in   asynchronous active-low reset
//   cs             in   host chip select, active low (async)
//   wren           in   host write enable, active low; 1 = read (async)
//   rs[3:0]        in   register select (async)
//   data_in[7:0]   in   host write data (async)
//   data_out[7:0]  out  read data, register[rs_s]
//   data_oe        out  pad drive enable (~cs_s & wren_s)
//   mode[1:0]      out  MODE register, display mode select
//   scr_wr_ready   in   screen RAM can accept a write this cycle
//   scr_wr_en      out  screen RAM write strobe
//   scr_wr_addr    out  screen RAM write address
//   scr_wr_data    out  screen RAM write data
//   fifo_level     out  current FIFO entry count
//
// Register map (rs)
//   0 MODE (R/W, bits 1:0)   1 DATA (W, push)   3 ADDR_LO   4 ADDR_HI
//   5 CTRL (bit0 autoinc, bit1 flush, self-clearing)
//   6 STATUS (R: bit0 empty, bit1 full, bit2 overflow; a read commit
//     clears overflow)

module host_bus_write_queue #(
    parameter  int DEPTH       = 16,
    parameter  int SYNC_STAGES = 2,
    localparam int AW          = $clog2(DEPTH),
    localparam int LW          = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic          wren,
    input  logic [3:0]    rs,
    input  logic [7:0]    data_in,
    output logic [7:0]    data_out,
    output logic          data_oe,
    output logic [1:0]    mode,
    input  logic          scr_wr_ready,
    output logic          scr_wr_en,
    output logic [15:0]   scr_wr_addr,
    output logic [7:0]    scr_wr_data,
    output logic [LW-1:0] fifo_level
);

    localparam logic [3:0] RS_MODE    = 4'd0;
    localparam logic [3:0] RS_DATA    = 4'd1;
    localparam logic [3:0] RS_ADDR_LO = 4'd3;
    localparam logic [3:0] RS_ADDR_HI = 4'd4;
    localparam logic [3:0] RS_CTRL    = 4'd5;
    localparam logic [3:0] RS_STATUS  = 4'd6;

    // Synchronizer chains, stage 0 samples the pad.
    logic [SYNC_STAGES-1:0]      cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0]      wren_sync_q, wren_sync_d;
    logic [SYNC_STAGES-1:0][3:0] rs_sync_q,   rs_sync_d;
    logic [SYNC_STAGES-1:0][7:0] data_sync_q, data_sync_d;

    logic       cs_s, wren_s;
    logic [3:0] rs_s;
    logic [7:0] data_s;

    // Shadow of the bus while cs is low, plus cs edge detector.
    logic       cs_prev_q,  cs_prev_d;
    logic [3:0] sh_rs_q,    sh_rs_d;
    logic       sh_wren_q,  sh_wren_d;
    logic [7:0] sh_data_q,  sh_data_d;

    // Register file.
    logic [1:0]  mode_q, mode_d;
    logic [15:0] addr_q, addr_d;
    logic        ovf_q,  ovf_d;
    logic        autoinc;

    // FIFO.
    logic [23:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q,  count_d;
    logic [23:0]   head;

    // Registered screen RAM write port.
    logic        wr_en_q,   wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    // Decoded commit strobes.
    logic commit, wr_commit, rd_commit;
    logic data_wr, ctrl_wr, status_rd, flush;
    logic empty, full, pop, push, ovf_set;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    always_comb begin
        cs_sync_d      = cs_sync_q;
        wren_sync_d    = wren_sync_q;
        rs_sync_d      = rs_sync_q;
        data_sync_d    = data_sync_q;
        cs_sync_d[0]   = cs;
        wren_sync_d[0] = wren;
        rs_sync_d[0]   = rs;
        data_sync_d[0] = data_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            cs_sync_d[i]   = cs_sync_q[i-1];
            wren_sync_d[i] = wren_sync_q[i-1];
            rs_sync_d[i]   = rs_sync_q[i-1];
            data_sync_d[i] = data_sync_q[i-1];
        end
    end

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign wren_s = wren_sync_q[SYNC_STAGES-1];
    assign rs_s   = rs_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Shadow capture and commit decode
    // ------------------------------------------------------------------
    always_comb begin
        cs_prev_d = cs_s;
        sh_rs_d   = sh_rs_q;
        sh_wren_d = sh_wren_q;
        sh_data_d = sh_data_q;
        if (!cs_s) begin
            sh_rs_d   = rs_s;
            sh_wren_d = wren_s;
            sh_data_d = data_s;
        end
    end

    assign commit    = cs_s & ~cs_prev_q;
    assign wr_commit = commit & ~sh_wren_q;
    assign rd_commit = commit &  sh_wren_q;
    assign data_wr   = wr_commit & (sh_rs_q == RS_DATA);
    assign ctrl_wr   = wr_commit & (sh_rs_q == RS_CTRL);
    assign status_rd = rd_commit & (sh_rs_q == RS_STATUS);
    assign flush     = ctrl_wr & sh_data_q[1];

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign empty = (count_q == '0);
    assign full  = (count_q == LW'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // A flush cancels the pop; a full FIFO still accepts a push when a
    // pop frees a slot in the same cycle.
    assign pop     = ~empty & scr_wr_ready & ~flush;
    assign push    = data_wr & (~full | pop);
    assign ovf_set = data_wr & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {addr_q, sh_data_q};
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
`ifdef FGA_AUTOINC_EN
    logic autoinc_q, autoinc_d;

    always_comb begin
        autoinc_d = autoinc_q;
        if (ctrl_wr) begin
            autoinc_d = sh_data_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            autoinc_q <= 1'b1;
        end else begin
            autoinc_q <= autoinc_d;
        end
    end

    assign autoinc = autoinc_q;
`else
    assign autoinc = 1'b0;
`endif

    always_comb begin
        mode_d = mode_q;
        addr_d = addr_q;
        ovf_d  = ovf_q;
        if (wr_commit) begin
            case (sh_rs_q)
                RS_MODE:    mode_d        = sh_data_q[1:0];
                RS_ADDR_LO: addr_d[7:0]   = sh_data_q;
                RS_ADDR_HI: addr_d[15:8]  = sh_data_q;
                default:    ;
            endcase
        end
`ifdef FGA_AUTOINC_EN
        if (push && autoinc) begin
            addr_d = addr_q + 16'd1;
        end
`endif
        // Set beats clear when both land in one cycle.
        if (status_rd) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Screen RAM write port
    // ------------------------------------------------------------------
    always_comb begin
        wr_en_d   = pop;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (pop) begin
            wr_addr_d = head[23:8];
            wr_data_d = head[7:0];
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // cs idles high so reset never manufactures a commit edge.
            cs_sync_q   <= '1;
            wren_sync_q <= '0;
            rs_sync_q   <= '0;
            data_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sh_rs_q     <= '0;
            sh_wren_q   <= 1'b0;
            sh_data_q   <= '0;
            mode_q      <= '0;
            addr_q      <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            wren_sync_q <= wren_sync_d;
            rs_sync_q   <= rs_sync_d;
            data_sync_q <= data_sync_d;
            cs_prev_q   <= cs_prev_d;
            sh_rs_q     <= sh_rs_d;
            sh_wren_q   <= sh_wren_d;
            sh_data_q   <= sh_data_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path, combinational from the synchronised bus
    // ------------------------------------------------------------------
    always_comb begin
        data_out = 8'h00;
        case (rs_s)
            RS_MODE:    data_out = {6'b0, mode_q};
            RS_ADDR_LO: data_out = addr_q[7:0];
            RS_ADDR_HI: data_out = addr_q[15:8];
            RS_CTRL:    data_out = {7'b0, autoinc};
            RS_STATUS:  data_out = {5'b0, ovf_q, full, empty};
            default:    data_out = 8'h00;
        endcase
    end

    assign data_oe     = ~cs_s & wren_s;
    assign mode        = mode_q;
    assign scr_wr_en   = wr_en_q;
    assign scr_wr_addr = wr_addr_q;
    assign scr_wr_data = wr_data_q;
    assign fifo_level  = count_q;

endmodule
